// File: rtl/life_ctrl_if.sv
// Command/status bundle between a host and the life_ctrl generation controller.
// Commands are single-cycle requests sampled on every rising edge; there is no ready signal.
// The controller reports acceptance only through state, busy and the arr_en/arr_rst strobes.
interface life_ctrl_if #(
    parameter int PERIOD_W = 16,
    parameter int GEN_W    = 16
);
    logic                cmd_load;
    logic                cmd_run;
    logic                cmd_stop;
    logic                cmd_step;
    logic [PERIOD_W-1:0] period;
    logic [GEN_W-1:0]    max_gen;
    logic                all_dead;
    logic                arr_rst;
    logic                arr_en;
    logic [GEN_W-1:0]    gen_count;
    logic [2:0]          state;
    logic                busy;
    logic                done;
    logic                extinct;

    modport master (
        output cmd_load, cmd_run, cmd_stop, cmd_step, period, max_gen, all_dead,
        input  arr_rst, arr_en, gen_count, state, busy, done, extinct
    );

    modport slave (
        input  cmd_load, cmd_run, cmd_stop, cmd_step, period, max_gen, all_dead,
        output arr_rst, arr_en, gen_count, state, busy, done, extinct
    );
endinterface

// File: rtl/life_ctrl.sv
// Sequencer for a Game-of-Life cell array: seed load, single step, timed free-run,
// and halting on a generation limit or on extinction of every cell.
module life_ctrl #(
    parameter int PERIOD_W = 16,
    parameter int GEN_W    = 16,
    parameter int LOAD_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    life_ctrl_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PAUSED = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]          state_q, state_d;
    logic                arr_rst_q, arr_rst_d;
    logic                arr_en_q, arr_en_d;
    logic                chk_q, chk_d;
    logic [GEN_W-1:0]    gen_count_q, gen_count_d;
    logic                done_q, done_d;
    logic                extinct_q, extinct_d;
    logic                busy_q, busy_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [3:0]          load_cnt_q, load_cnt_d;

    logic [PERIOD_W-1:0] interval;
    logic                dead_hit;
    logic                max_hit;
    logic                halt_hit;

    // Intervals below 2 would put arr_en in back-to-back cycles, colliding with the check cycle.
    assign interval = (bus.period < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.period;

    // chk_q marks the cycle right after an arr_en pulse, when all_dead and the limit are judged.
    assign dead_hit = chk_q && bus.all_dead;
    assign max_hit  = chk_q && (bus.max_gen != '0) && (gen_count_q == bus.max_gen);
    assign halt_hit = dead_hit || max_hit;

    always_comb begin
        state_d     = state_q;
        arr_rst_d   = 1'b0;
        arr_en_d    = 1'b0;
        chk_d       = arr_en_q;
        gen_count_d = gen_count_q;
        done_d      = done_q;
        extinct_d   = extinct_q;
        timer_d     = timer_q;
        load_cnt_d  = load_cnt_q;

        if (arr_en_q && (gen_count_q != '1)) begin
            gen_count_d = gen_count_q + GEN_W'(1);
        end

        if (bus.cmd_load) begin
            state_d     = S_LOAD;
            arr_rst_d   = 1'b1;
            load_cnt_d  = 4'(LOAD_CYC - 1);
            gen_count_d = '0;
            done_d      = 1'b0;
            extinct_d   = 1'b0;
            chk_d       = 1'b0;
            timer_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (load_cnt_q == 4'd0) begin
                        state_d = S_PAUSED;
                    end else begin
                        arr_rst_d  = 1'b1;
                        load_cnt_d = load_cnt_q - 4'd1;
                    end
                end
                S_PAUSED: begin
                    if (halt_hit) begin
                        state_d   = S_HALTED;
                        done_d    = max_hit;
                        extinct_d = dead_hit;
                    end else if (bus.cmd_stop) begin
                        state_d = S_PAUSED;
                    end else if (bus.cmd_run) begin
                        state_d = S_RUN;
                        timer_d = interval;
                    end else if (bus.cmd_step && !arr_en_q && !chk_q) begin
                        arr_en_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (halt_hit) begin
                        state_d   = S_HALTED;
                        done_d    = max_hit;
                        extinct_d = dead_hit;
                    end else if (bus.cmd_stop) begin
                        state_d = S_PAUSED;
                    end else if (timer_q <= PERIOD_W'(1)) begin
                        arr_en_d = 1'b1;
                        timer_d  = interval;
                    end else begin
                        timer_d = timer_q - PERIOD_W'(1);
                    end
                end
                S_HALTED: ;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            arr_rst_q   <= 1'b1;
            arr_en_q    <= 1'b0;
            chk_q       <= 1'b0;
            gen_count_q <= '0;
            done_q      <= 1'b0;
            extinct_q   <= 1'b0;
            busy_q      <= 1'b0;
            timer_q     <= '0;
            load_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            arr_rst_q   <= arr_rst_d;
            arr_en_q    <= arr_en_d;
            chk_q       <= chk_d;
            gen_count_q <= gen_count_d;
            done_q      <= done_d;
            extinct_q   <= extinct_d;
            busy_q      <= busy_d;
            timer_q     <= timer_d;
            load_cnt_q  <= load_cnt_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.arr_rst   = arr_rst_q;
    assign bus.arr_en    = arr_en_q;
    assign bus.gen_count = gen_count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.extinct   = extinct_q;
endmodule

// File: doc/life_ctrl.md
LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 Parameter PERIOD_W, default 16, width of the generation-interval input.
REQ-002 Parameter GEN_W, default 16, width of the generation counter and limit.
REQ-003 Parameter LOAD_CYC, default 2, number of cycles arr_rst is held high during LOAD; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_load  in  1  request to reload the seed pattern into the cell array.
REQ-007 cmd_run  in  1  request free-running generation stepping.
REQ-008 cmd_stop  in  1  request to pause free-running.
REQ-009 cmd_step  in  1  request for exactly one generation while paused.
REQ-010 period  in  PERIOD_W  clock cycles between generations in RUN.
REQ-011 max_gen  in  GEN_W  generation limit; 0 = unlimited.
REQ-012 all_dead  in  1  high when every cell alive output of the array is 0.
REQ-013 arr_rst  out  1  drives the array's synchronous active-high rst (seed capture).
REQ-014 arr_en  out  1  one-cycle generation enable to the array.
REQ-015 gen_count  out  GEN_W  generations completed since last LOAD.
REQ-016 state  out  3  IDLE=0, LOAD=1, PAUSED=2, RUN=3, HALTED=4.
REQ-017 busy  out  1  high in LOAD or RUN.
REQ-018 done  out  1  high in HALTED when max_gen was reached.
REQ-019 extinct  out  1  high in HALTED when all_dead ended the run.

Function
REQ-020 All outputs SHALL be registered; command inputs SHALL be sampled once per rising edge.
REQ-021 Command priority SHALL be cmd_load > cmd_stop > cmd_run > cmd_step when asserted together.
REQ-022 cmd_load SHALL be accepted in every state and move to LOAD on the next edge, aborting any step in progress.
REQ-023 LOAD: arr_rst=1 for exactly LOAD_CYC cycles, gen_count cleared to 0, done/extinct cleared, then PAUSED.
REQ-024 IDLE: only cmd_load is accepted; cmd_run, cmd_stop and cmd_step are ignored.
REQ-025 PAUSED: cmd_step SHALL assert arr_en for one cycle in the cycle after sampling; further cmd_step is ignored until the check cycle completes.
REQ-026 PAUSED: cmd_run SHALL enter RUN and load the interval timer.
REQ-027 RUN effective interval SHALL be max(period, 2); the first arr_en occurs interval cycles after the cmd_run sample edge, then every interval cycles.
REQ-028 RUN: cmd_stop SHALL enter PAUSED on the next edge; an arr_en already asserted in that cycle completes and is counted.
REQ-029 gen_count SHALL increment on the edge ending each arr_en cycle and saturate at all-ones.
REQ-030 The cycle after each arr_en is the check cycle: if all_dead=1, go to HALTED with extinct=1.
REQ-031 In the check cycle, if max_gen!=0 and gen_count==max_gen, go to HALTED with done=1; both flags SHALL be set if both conditions hold.
REQ-032 HALTED: arr_en SHALL stay 0; only cmd_load exits.
REQ-033 arr_en SHALL never be high in IDLE, LOAD or HALTED, nor in two consecutive cycles.

Reset
REQ-034 While rst_n=0: state=IDLE, arr_rst=1, arr_en=0, gen_count=0, busy=0, done=0, extinct=0, timer=0.
REQ-035 arr_rst SHALL drop to 0 on the first rising edge after rst_n deasserts.
REQ-036 Reset asserted mid-RUN or mid-LOAD SHALL take effect immediately without waiting for clk.

Verification
REQ-037 Reset release, cmd_load pulse, LOAD_CYC=2 -> arr_rst high exactly 2 cycles, state goes 0->1->2, gen_count=0.
REQ-038 PAUSED, three cmd_step pulses spaced 4 cycles apart -> three single-cycle arr_en pulses, gen_count=3, state stays 2.
REQ-039 RUN with period=5, max_gen=4 -> arr_en every 5 cycles, HALTED after 4th check cycle, done=1, extinct=0.
REQ-040 RUN with period=0 -> arr_en every 2 cycles; cmd_stop and cmd_run in the same cycle -> PAUSED.
REQ-041 RUN, all_dead=1 during the check cycle after generation 7 -> HALTED, extinct=1, gen_count=7.
REQ-042 rst_n low mid-RUN between clock edges -> outputs take reset values immediately; cmd_load during RUN -> LOAD, gen_count=0.
